// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for RISC_TOY.
// Holds the decoded instruction for the execute stage. Operands are
// forwarded from MEM/WB so the ALU inputs always carry the newest values.
// Load-use hazards against the instruction in decode are flagged here.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          VALID_D,
  input  logic [3:0]    ALUOP_D,
  input  logic [DW-1:0] RD1_D,
  input  logic [DW-1:0] RD2_D,
  input  logic [DW-1:0] IMM_D,
  input  logic          BSEL_D,
  input  logic [RW-1:0] RS1_D,
  input  logic [RW-1:0] RS2_D,
  input  logic [RW-1:0] RD_D,
  input  logic          REGWRITE_D,
  input  logic          MEMREAD_D,
  input  logic          MEMWRITE_D,
  input  logic          STALL_E,
  input  logic          FLUSH_E,
  input  logic [DW-1:0] ALUOUT_M,
  input  logic [RW-1:0] RD_M,
  input  logic          REGWRITE_M,
  input  logic          MEMREAD_M,
  input  logic [DW-1:0] RESULT_W,
  input  logic [RW-1:0] RD_W,
  input  logic          REGWRITE_W,
  output logic [3:0]    ALUOP_E,
  output logic [DW-1:0] ALUSRC1,
  output logic [DW-1:0] ALUSRC2,
  output logic [DW-1:0] WDATA_E,
  output logic [RW-1:0] RD_E,
  output logic          REGWRITE_E,
  output logic          MEMREAD_E,
  output logic          MEMWRITE_E,
  output logic          VALID_E,
  output logic          LU_HAZARD
);

  // Captured operands and register indices.
  logic [DW-1:0] rd1_e;
  logic [DW-1:0] rd2_e;
  logic [DW-1:0] imm_e;
  logic          bsel_e;
  logic [RW-1:0] rs1_e;
  logic [RW-1:0] rs2_e;

  // Forwarded operand values.
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;

  // The hazard unit never lets a MEM-stage load be a forwarding source,
  // so the load flag of the MEM stage plays no part in the mux selects.
  logic unused_memread_m;
  assign unused_memread_m = MEMREAD_M;

  // Register update happens on flush or when not stalled; a flush, or an
  // invalid decode slot, loads an all-zero bubble instead of the D fields.
  logic load_e;
  logic take_bubble;
  assign load_e      = FLUSH_E | ~STALL_E;
  assign take_bubble = FLUSH_E | ~VALID_D;

  // E register: async clear, flush beats stall, otherwise capture decode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ALUOP_E    <= '0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      imm_e      <= '0;
      bsel_e     <= 1'b0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      RD_E       <= '0;
      REGWRITE_E <= 1'b0;
      MEMREAD_E  <= 1'b0;
      MEMWRITE_E <= 1'b0;
      VALID_E    <= 1'b0;
    end else if (load_e) begin
      if (take_bubble) begin
        ALUOP_E    <= '0;
        rd1_e      <= '0;
        rd2_e      <= '0;
        imm_e      <= '0;
        bsel_e     <= 1'b0;
        rs1_e      <= '0;
        rs2_e      <= '0;
        RD_E       <= '0;
        REGWRITE_E <= 1'b0;
        MEMREAD_E  <= 1'b0;
        MEMWRITE_E <= 1'b0;
        VALID_E    <= 1'b0;
      end else begin
        ALUOP_E    <= ALUOP_D;
        rd1_e      <= RD1_D;
        rd2_e      <= RD2_D;
        imm_e      <= IMM_D;
        bsel_e     <= BSEL_D;
        rs1_e      <= RS1_D;
        rs2_e      <= RS2_D;
        RD_E       <= RD_D;
        REGWRITE_E <= REGWRITE_D;
        MEMREAD_E  <= MEMREAD_D;
        MEMWRITE_E <= MEMWRITE_D;
        VALID_E    <= 1'b1;
      end
    end
  end

  // Forwarding muxes: MEM beats WB, register 0 is never forwarded; live
  // during stalls so values retiring while E is held are still seen.
  always_comb begin
    fwd1 = rd1_e;
    fwd2 = rd2_e;
    if (REGWRITE_M && (RD_M != '0) && (RD_M == rs1_e))
      fwd1 = ALUOUT_M;
    else if (REGWRITE_W && (RD_W != '0) && (RD_W == rs1_e))
      fwd1 = RESULT_W;
    if (REGWRITE_M && (RD_M != '0) && (RD_M == rs2_e))
      fwd2 = ALUOUT_M;
    else if (REGWRITE_W && (RD_W != '0) && (RD_W == rs2_e))
      fwd2 = RESULT_W;
  end

  assign ALUSRC1 = fwd1;
  assign ALUSRC2 = bsel_e ? imm_e : fwd2;
  assign WDATA_E = fwd2;

  // A load in E whose destination is read by the instruction in decode.
  assign LU_HAZARD = VALID_E & MEMREAD_E & (RD_E != '0) & VALID_D &
                     ((RD_E == RS1_D) | (RD_E == RS2_D));

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the E register and forwarding.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          VALID_D;
  logic [3:0]    ALUOP_D;
  logic [DW-1:0] RD1_D, RD2_D, IMM_D;
  logic          BSEL_D;
  logic [RW-1:0] RS1_D, RS2_D, RD_D;
  logic          REGWRITE_D, MEMREAD_D, MEMWRITE_D;
  logic          STALL_E, FLUSH_E;
  logic [DW-1:0] ALUOUT_M;
  logic [RW-1:0] RD_M;
  logic          REGWRITE_M, MEMREAD_M;
  logic [DW-1:0] RESULT_W;
  logic [RW-1:0] RD_W;
  logic          REGWRITE_W;
  logic [3:0]    ALUOP_E;
  logic [DW-1:0] ALUSRC1, ALUSRC2, WDATA_E;
  logic [RW-1:0] RD_E;
  logic          REGWRITE_E, MEMREAD_E, MEMWRITE_E, VALID_E, LU_HAZARD;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .CLK(CLK), .RST(RST), .VALID_D(VALID_D), .ALUOP_D(ALUOP_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .IMM_D(IMM_D), .BSEL_D(BSEL_D),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D), .REGWRITE_D(REGWRITE_D),
    .MEMREAD_D(MEMREAD_D), .MEMWRITE_D(MEMWRITE_D), .STALL_E(STALL_E),
    .FLUSH_E(FLUSH_E), .ALUOUT_M(ALUOUT_M), .RD_M(RD_M),
    .REGWRITE_M(REGWRITE_M), .MEMREAD_M(MEMREAD_M), .RESULT_W(RESULT_W),
    .RD_W(RD_W), .REGWRITE_W(REGWRITE_W), .ALUOP_E(ALUOP_E),
    .ALUSRC1(ALUSRC1), .ALUSRC2(ALUSRC2), .WDATA_E(WDATA_E), .RD_E(RD_E),
    .REGWRITE_E(REGWRITE_E), .MEMREAD_E(MEMREAD_E), .MEMWRITE_E(MEMWRITE_E),
    .VALID_E(VALID_E), .LU_HAZARD(LU_HAZARD)
  );

  // Model of the instruction sitting in execute.
  typedef struct {
    logic [3:0]    aluop;
    logic [DW-1:0] rd1, rd2, imm;
    logic          bsel;
    logic [RW-1:0] rs1, rs2, rd;
    logic          rw, mr, mw, v;
  } instr_t;

  instr_t m;

  function automatic instr_t bubble();
    instr_t b;
    b.aluop = '0; b.rd1 = '0; b.rd2 = '0; b.imm = '0; b.bsel = 1'b0;
    b.rs1 = '0; b.rs2 = '0; b.rd = '0;
    b.rw = 1'b0; b.mr = 1'b0; b.mw = 1'b0; b.v = 1'b0;
    return b;
  endfunction

  // Newest value of a register as seen by execute.
  function automatic logic [DW-1:0] newest(logic [RW-1:0] idx, logic [DW-1:0] rf);
    if (idx != 0 && REGWRITE_M && RD_M == idx) return ALUOUT_M;
    if (idx != 0 && REGWRITE_W && RD_W == idx) return RESULT_W;
    return rf;
  endfunction

  task automatic model_edge();
    if (RST || FLUSH_E || (!STALL_E && !VALID_D)) begin
      m = bubble();
    end else if (!STALL_E) begin
      m.aluop = ALUOP_D; m.rd1 = RD1_D; m.rd2 = RD2_D; m.imm = IMM_D;
      m.bsel = BSEL_D; m.rs1 = RS1_D; m.rs2 = RS2_D; m.rd = RD_D;
      m.rw = REGWRITE_D; m.mr = MEMREAD_D; m.mw = MEMWRITE_D; m.v = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [DW-1:0] f1, f2;
    logic          lu;
    f1 = newest(m.rs1, m.rd1);
    f2 = newest(m.rs2, m.rd2);
    lu = m.v && m.mr && m.rd != 0 && VALID_D && (m.rd == RS1_D || m.rd == RS2_D);
    chk("aluop_e",    {28'd0, ALUOP_E}, {28'd0, m.aluop});
    chk("alusrc1",    ALUSRC1, f1);
    chk("alusrc2",    ALUSRC2, m.bsel ? m.imm : f2);
    chk("wdata_e",    WDATA_E, f2);
    chk("rd_e",       {27'd0, RD_E}, {27'd0, m.rd});
    chk("regwrite_e", {31'd0, REGWRITE_E}, {31'd0, m.rw});
    chk("memread_e",  {31'd0, MEMREAD_E}, {31'd0, m.mr});
    chk("memwrite_e", {31'd0, MEMWRITE_E}, {31'd0, m.mw});
    chk("valid_e",    {31'd0, VALID_E}, {31'd0, m.v});
    chk("lu_hazard",  {31'd0, LU_HAZARD}, {31'd0, lu});
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic clear_mw();
    ALUOUT_M = '0; RD_M = '0; REGWRITE_M = 1'b0; MEMREAD_M = 1'b0;
    RESULT_W = '0; RD_W = '0; REGWRITE_W = 1'b0;
  endtask

  task automatic set_d(input logic v, input logic [3:0] op,
                       input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                       input logic [DW-1:0] imm, input logic bs,
                       input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                       input logic [RW-1:0] d, input logic rw,
                       input logic mr, input logic mw);
    VALID_D = v; ALUOP_D = op; RD1_D = r1; RD2_D = r2; IMM_D = imm;
    BSEL_D = bs; RS1_D = s1; RS2_D = s2; RD_D = d;
    REGWRITE_D = rw; MEMREAD_D = mr; MEMWRITE_D = mw;
  endtask

  initial begin
    // Reset with decode active: everything reads zero.
    RST = 1'b1; STALL_E = 1'b0; FLUSH_E = 1'b0;
    clear_mw();
    set_d(1'b1, 4'd9, 32'h11, 32'h22, 32'h33, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
    m = bubble();
    #1;
    check_all();
    tick();
    chk("reset_alusrc2", ALUSRC2, 32'd0);

    // First capture after reset.
    @(negedge CLK);
    RST = 1'b0;
    set_d(1'b1, 4'd1, 32'd5, 32'd7, 32'd0, 1'b0, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    chk("first_aluop", {28'd0, ALUOP_E}, 32'd1);
    chk("first_src1", ALUSRC1, 32'd5);
    chk("first_src2", ALUSRC2, 32'd7);

    // MEM beats WB, then WB alone.
    @(negedge CLK);
    set_d(1'b1, 4'd2, 32'h10, 32'h20, 32'd0, 1'b0, 5'd3, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    RD_M = 5'd3; REGWRITE_M = 1'b1; ALUOUT_M = 32'hAA;
    RD_W = 5'd3; REGWRITE_W = 1'b1; RESULT_W = 32'hBB;
    #1;
    check_all();
    chk("fwd_mem_prio", ALUSRC1, 32'hAA);
    REGWRITE_M = 1'b0;
    #1;
    check_all();
    chk("fwd_wb", ALUSRC1, 32'hBB);

    // Register 0 never forwarded.
    @(negedge CLK);
    clear_mw();
    set_d(1'b1, 4'd3, 32'h44, 32'd0, 32'd0, 1'b0, 5'd1, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1);
    RD_M = 5'd0; REGWRITE_M = 1'b1; ALUOUT_M = 32'hFF;
    tick();
    chk("r0_src2", ALUSRC2, 32'd0);
    chk("r0_wdata", WDATA_E, 32'd0);

    // Immediate select with rs2 forward active.
    @(negedge CLK);
    clear_mw();
    set_d(1'b1, 4'd4, 32'h1, 32'h2, 32'hFFFF_FFF0, 1'b1, 5'd1, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1);
    RD_M = 5'd6; REGWRITE_M = 1'b1; ALUOUT_M = 32'h1234;
    tick();
    chk("imm_src2", ALUSRC2, 32'hFFFF_FFF0);
    chk("imm_wdata", WDATA_E, 32'h1234);

    // Load-use hazard, then flush+stall together: flush wins.
    @(negedge CLK);
    clear_mw();
    set_d(1'b1, 4'd5, 32'h0, 32'h0, 32'h8, 1'b1, 5'd2, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge CLK);
    set_d(1'b1, 4'd6, 32'h3, 32'h4, 32'h0, 1'b0, 5'd1, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    check_all();
    chk("lu_set", {31'd0, LU_HAZARD}, 32'd1);
    FLUSH_E = 1'b1; STALL_E = 1'b1;
    tick();
    chk("flush_valid", {31'd0, VALID_E}, 32'd0);
    chk("flush_rd", {27'd0, RD_E}, 32'd0);
    chk("flush_lu", {31'd0, LU_HAZARD}, 32'd0);

    // Stall hold for three cycles; WB value arriving during the stall.
    @(negedge CLK);
    FLUSH_E = 1'b0; STALL_E = 1'b0;
    set_d(1'b1, 4'd7, 32'h55, 32'h66, 32'h0, 1'b0, 5'd10, 5'd11, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      STALL_E = 1'b1;
      set_d(1'b1, 4'($urandom), $urandom, $urandom, $urandom, 1'b0,
            5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      if (i == 1) begin RD_W = 5'd10; REGWRITE_W = 1'b1; RESULT_W = 32'hC0DE; end
      tick();
      chk("stall_aluop", {28'd0, ALUOP_E}, 32'd7);
    end
    chk("stall_wb_fwd", ALUSRC1, 32'hC0DE);
    chk("stall_src2", ALUSRC2, 32'h66);
    @(negedge CLK);
    STALL_E = 1'b0;
    clear_mw();
    tick();
    chk("resume_rd", {27'd0, RD_E}, 32'd3);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      RST     = ($urandom_range(0, 49) == 0);
      FLUSH_E = ($urandom_range(0, 9) == 0);
      STALL_E = ($urandom_range(0, 4) == 0);
      set_d($urandom_range(0, 6) != 0, 4'($urandom), $urandom, $urandom,
            $urandom, 1'($urandom), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 1'($urandom));
      ALUOUT_M = $urandom; RD_M = 5'($urandom_range(0, 7)); REGWRITE_M = 1'($urandom);
      MEMREAD_M = 1'b0;
      RESULT_W = $urandom; RD_W = 5'($urandom_range(0, 7)); REGWRITE_W = 1'($urandom);
      if (RST) m = bubble();
      tick();
      ALUOUT_M = $urandom; RD_M = 5'($urandom_range(0, 7)); REGWRITE_M = 1'($urandom);
      RESULT_W = $urandom; RD_W = 5'($urandom_range(0, 7)); REGWRITE_W = 1'($urandom);
      #1;
      check_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for RISC_TOY.
- Captures decoded operands and control, forwards results from the MEM and WB stages, and drives the execute-stage ALU inputs (ALUOP_E, ALUSRC1, ALUSRC2).
- Detects load-use hazards against the instruction currently in decode and handles stall and flush (bubble insertion).

Parameters:
DW, 32, datapath width; ALU operands and results.
RW, 5, register-index width.

Ports:
CLK  in  1  clock; all registers update on the rising edge.
RST  in  1  asynchronous reset, active-high.
VALID_D  in  1  decode holds a real instruction.
ALUOP_D  in  4  ALU opcode from decode (0 = zero result).
RD1_D  in  DW  register-file read data for rs1.
RD2_D  in  DW  register-file read data for rs2.
IMM_D  in  DW  sign-extended immediate.
BSEL_D  in  1  1 = ALUSRC2 takes the immediate; 0 = ALUSRC2 takes forwarded rs2.
RS1_D  in  RW  rs1 index.
RS2_D  in  RW  rs2 index.
RD_D  in  RW  destination index.
REGWRITE_D  in  1  write-back enable.
MEMREAD_D  in  1  load.
MEMWRITE_D  in  1  store.
STALL_E  in  1  hold the E register (external stall).
FLUSH_E  in  1  load a bubble into the E register.
ALUOUT_M  in  DW  MEM-stage result.
RD_M  in  RW  MEM-stage destination.
REGWRITE_M  in  1  MEM-stage write enable.
MEMREAD_M  in  1  MEM-stage instruction is a load.
RESULT_W  in  DW  WB-stage result.
RD_W  in  RW  WB-stage destination.
REGWRITE_W  in  1  WB-stage write enable.
ALUOP_E  out  4  registered ALU opcode.
ALUSRC1  out  DW  forwarded rs1 value.
ALUSRC2  out  DW  immediate or forwarded rs2 value.
WDATA_E  out  DW  forwarded rs2 value, used as store data.
RD_E  out  RW  registered destination.
REGWRITE_E, MEMREAD_E, MEMWRITE_E, VALID_E  out  1 each  registered control.
LU_HAZARD  out  1  load-use hazard; combinational.

Behaviour:
- Reset (RST=1, asynchronous): all E registers clear to 0, including ALUOP_E, RD_E, controls, VALID_E, and the captured RS/RD/data. Outputs therefore read 0 (ALUSRC2=0 because BSEL clears to 0 and no forwarding is active). Reset asserted mid-stall also clears.
- Per rising edge, priority order:
  - FLUSH_E=1: load a bubble; this overrides STALL_E.
  - Else STALL_E=1: hold all E registers.
  - Else capture all *_D inputs.
- Bubble: ALUOP=0, all controls=0, VALID=0, RD=0; data fields don't-care (cleared to 0).
- Any control field with VALID_D=0 is captured as a bubble.
- Latency: one cycle, D to E.
- Forwarding (combinational from the registered RS1_E/RS2_E), evaluated independently for each of rs1 and rs2:
  - Take ALUOUT_M if REGWRITE_M, RD_M!=0 and RD_M==RSx_E.
  - Else take RESULT_W if REGWRITE_W, RD_W!=0 and RD_W==RSx_E.
  - Else take the captured register-file value.
  - Register 0 is never forwarded.
  - MEM has priority over WB.
  - Forwarding from a MEM-stage load (MEMREAD_M=1) is not legal; hazard logic guarantees it never occurs.
- ALUSRC1 = fwd1. ALUSRC2 = BSEL_E ? IMM_E : fwd2. WDATA_E = fwd2 regardless of BSEL.
- Forwarding muxes are re-evaluated every cycle, including during a stall, so a value arriving in WB while E is held is still picked up.
- LU_HAZARD = VALID_E & MEMREAD_E & (RD_E!=0) & VALID_D & ((RD_E==RS1_D) | (RD_E==RS2_D)).
  - The hazard unit uses LU_HAZARD to stall F/D and assert FLUSH_E.
  - This block does not self-flush.
- Arithmetic: no width changes; all data paths are DW bits, pass-through.

Test Plan:
- Reset: RST=1 with D inputs active -> all outputs 0 and LU_HAZARD=0. Release RST; next edge with VALID_D=1, ALUOP_D=1, RD1_D=5, RD2_D=7 -> ALUOP_E=1, ALUSRC1=5, ALUSRC2=7.
- Forwarding priority: RS1_E=3, RD_M=3, REGWRITE_M=1, ALUOUT_M=0xAA, RD_W=3, REGWRITE_W=1, RESULT_W=0xBB -> ALUSRC1=0xAA. Drop REGWRITE_M -> ALUSRC1=0xBB.
- Register 0: RS2_E=0, RD_M=0, REGWRITE_M=1, ALUOUT_M=0xFF, BSEL_E=0 -> ALUSRC2=captured RD2 (0); WDATA_E identical.
- Immediate select: BSEL_D=1, IMM_D=0xFFFFFFF0, rs2 forward active -> ALUSRC2=0xFFFFFFF0, WDATA_E=forwarded value.
- Load-use: E holds a load with RD_E=4; D has RS2_D=4, VALID_D=1 -> LU_HAZARD=1. With FLUSH_E=1 and STALL_E=1 together, next edge -> VALID_E=0, ALUOP_E=0, RD_E=0 (flush wins), LU_HAZARD=0.
- Stall hold: STALL_E=1 for 3 cycles with D inputs changing -> E outputs unchanged except forwarded values tracking M/W; capture resumes on the first edge after STALL_E=0.
